// File: rtl/counter_cba_down_if.sv
// counter_cba_down_if: groups the counter's request inputs and its status outputs.
// No latency and no storage; it only carries signals.
// No backpressure: start is a request pulse, hold freezes the active counting phase.
//
// Signals:
//   start, hold         request pulse / freeze, driven by the controller (master)
//   a, b, c             per-phase counter values, driven by the counter (slave)
//   phase, busy, done   state code and status flags, driven by the counter
interface counter_cba_down_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             hold;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [2:0]       phase;
    logic             busy;
    logic             done;

    modport master (
        output start, hold,
        input  a, b, c, phase, busy, done
    );

    modport slave (
        input  start, hold,
        output a, b, c, phase, busy, done
    );
endinterface

// File: rtl/counter_cba_down.sv
// counter_cba_down: loads a/b/c start values and counts them to zero in order c, b, a.
// Latency: loads visible one edge after start; done arrives C_INIT+B_INIT+A_INIT+4 edges later.
// Backpressure: hold freezes the active counting phase; start outside IDLE depends on macro.
//
// Ports:
//   clk     clock, all state updates on posedge
//   reset   synchronous, active-high
//   bus     counter_cba_down_if.slave (start, hold in; a, b, c, phase, busy, done out)
//
// Optional feature macro: COUNTER_CBA_RESTART_EN
//   defined   - start in C, B, A or DONE reloads all counters and re-enters C (overrides hold)
//   undefined - start is accepted only in IDLE
module counter_cba_down #(
    parameter int WIDTH  = 3,
    parameter int A_INIT = 5,
    parameter int B_INIT = 6,
    parameter int C_INIT = 7
) (
    input  logic                clk,
    input  logic                reset,
    counter_cba_down_if.slave   bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_C    = 3'd1;
    localparam logic [2:0] ST_B    = 3'd2;
    localparam logic [2:0] ST_A    = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [WIDTH-1:0] A_LD = WIDTH'(A_INIT);
    localparam logic [WIDTH-1:0] B_LD = WIDTH'(B_INIT);
    localparam logic [WIDTH-1:0] C_LD = WIDTH'(C_INIT);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Start values must fit in the counter width.
    if (A_INIT < 0 || A_INIT >= 2**WIDTH) begin : g_bad_a_init
        $error("counter_cba_down: A_INIT does not fit in WIDTH bits");
    end
    if (B_INIT < 0 || B_INIT >= 2**WIDTH) begin : g_bad_b_init
        $error("counter_cba_down: B_INIT does not fit in WIDTH bits");
    end
    if (C_INIT < 0 || C_INIT >= 2**WIDTH) begin : g_bad_c_init
        $error("counter_cba_down: C_INIT does not fit in WIDTH bits");
    end

    logic [2:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic             load;

`ifdef COUNTER_CBA_RESTART_EN
    // Any start reloads, even mid-sequence; the aborted run never reaches DONE.
    assign load = bus.start;
`else
    // A running sequence always completes; start only counts in IDLE.
    assign load = bus.start && (state == ST_IDLE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
        end else if (load) begin
            // Load takes priority over hold so a held phase can still be restarted.
            state <= ST_C;
            a_q   <= A_LD;
            b_q   <= B_LD;
            c_q   <= C_LD;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                // Zero is tested before decrementing, so each phase spends one
                // extra cycle at zero and the counters never wrap.
                ST_C: begin
                    if (!bus.hold) begin
                        if (c_q == '0) state <= ST_B;
                        else           c_q   <= c_q - ONE;
                    end
                end
                ST_B: begin
                    if (!bus.hold) begin
                        if (b_q == '0) state <= ST_A;
                        else           b_q   <= b_q - ONE;
                    end
                end
                ST_A: begin
                    if (!bus.hold) begin
                        if (a_q == '0) state <= ST_DONE;
                        else           a_q   <= a_q - ONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.c     = c_q;
    assign bus.phase = state;
    assign bus.busy  = (state == ST_C) || (state == ST_B) || (state == ST_A);
    assign bus.done  = (state == ST_DONE);

endmodule

// File: tb/tb_counter_cba_down.sv
// Directed bench for counter_cba_down: default instance plus an all-zero-INIT instance.
// Sample k is taken 1 time unit after edge N+k-1, i.e. it shows the value "at N+k".
module tb_counter_cba_down;

    logic clk;
    logic reset;

    counter_cba_down_if #(.WIDTH(3)) bus ();
    counter_cba_down_if #(.WIDTH(3)) bus0 ();

    counter_cba_down #(.WIDTH(3), .A_INIT(5), .B_INIT(6), .C_INIT(7)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    counter_cba_down #(.WIDTH(3), .A_INIT(0), .B_INIT(0), .C_INIT(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-sample record of the default instance, indexed by k.
    logic [2:0] ph_r [1:40];
    logic [2:0] a_r  [1:40];
    logic [2:0] b_r  [1:40];
    logic [2:0] c_r  [1:40];
    logic       dn_r [1:40];
    int done_at;
    int done_cnt;
    int busy_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start (with optional hold in IDLE), then record n samples.
    // After sample k the inputs for edge N+k are driven from the arguments.
    task automatic run_seq(input int n, input logic hold0, input int hold_lo, input int hold_hi,
                           input int rst_k, input int rs_k);
        done_at  = 0;
        done_cnt = 0;
        busy_cnt = 0;
        bus.start = 1'b1;
        bus.hold  = hold0;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            ph_r[k] = bus.phase;
            a_r[k]  = bus.a;
            b_r[k]  = bus.b;
            c_r[k]  = bus.c;
            dn_r[k] = bus.done;
            if (bus.done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (bus.busy) busy_cnt++;
            bus.hold  = (k >= hold_lo) && (k <= hold_hi);
            reset     = (k == rst_k);
            bus.start = (k == rs_k);
            tick();
        end
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        int ep, ea, eb, ec;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.hold   = 1'b0;
        bus0.start = 1'b0;
        bus0.hold  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_a", 32'(bus.a), 0);
        chk("rst_b", 32'(bus.b), 0);
        chk("rst_c", 32'(bus.c), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst0_phase", 32'(bus0.phase), 0);

        // Plain sequence: c 7..0, b 6..0, a 5..0, DONE, IDLE.
        run_seq(30, 1'b0, 0, 0, 0, 0);
        for (int k = 1; k <= 23; k++) begin
            if (k <= 8) begin
                ep = 1; ea = 5; eb = 6; ec = 8 - k;
            end else if (k <= 15) begin
                ep = 2; ea = 5; eb = 15 - k; ec = 0;
            end else if (k <= 21) begin
                ep = 3; ea = 21 - k; eb = 0; ec = 0;
            end else begin
                ep = (k == 22) ? 4 : 0; ea = 0; eb = 0; ec = 0;
            end
            chk($sformatf("seq_phase_k%0d", k), 32'(ph_r[k]), 32'(ep));
            chk($sformatf("seq_a_k%0d", k), 32'(a_r[k]), 32'(ea));
            chk($sformatf("seq_b_k%0d", k), 32'(b_r[k]), 32'(eb));
            chk($sformatf("seq_c_k%0d", k), 32'(c_r[k]), 32'(ec));
            chk($sformatf("seq_done_k%0d", k), 32'(dn_r[k]), 32'(k == 22));
        end
        chk("seq_done_at", 32'(done_at), 22);
        chk("seq_done_cnt", 32'(done_cnt), 1);
        chk("seq_busy_cnt", 32'(busy_cnt), 21);

        // Hold for three edges while b==3 (b shows 3 at k=12).
        run_seq(30, 1'b0, 12, 14, 0, 0);
        chk("hold_b_k12", 32'(b_r[12]), 3);
        chk("hold_b_k13", 32'(b_r[13]), 3);
        chk("hold_b_k15", 32'(b_r[15]), 3);
        chk("hold_b_k16", 32'(b_r[16]), 2);
        chk("hold_a_k15", 32'(a_r[15]), 5);
        chk("hold_done_at", 32'(done_at), 25);
        chk("hold_busy_cnt", 32'(busy_cnt), 24);

        // Reset at edge N+10, during phase B.
        run_seq(30, 1'b0, 0, 0, 10, 0);
        chk("rstmid_phase_k10", 32'(ph_r[10]), 2);
        chk("rstmid_b_k10", 32'(b_r[10]), 5);
        chk("rstmid_phase_k11", 32'(ph_r[11]), 0);
        chk("rstmid_a_k11", 32'(a_r[11]), 0);
        chk("rstmid_b_k11", 32'(b_r[11]), 0);
        chk("rstmid_c_k11", 32'(c_r[11]), 0);
        chk("rstmid_busy_cnt", 32'(busy_cnt), 10);
        chk("rstmid_done_at", 32'(done_at), 0);

        // Start again at edge N+5 while in phase C with c==3.
        run_seq(35, 1'b0, 0, 0, 0, 5);
        chk("rs_c_k5", 32'(c_r[5]), 3);
`ifdef COUNTER_CBA_RESTART_EN
        chk("rs_c_k6", 32'(c_r[6]), 7);
        chk("rs_done_at", 32'(done_at), 27);
`else
        chk("rs_c_k6", 32'(c_r[6]), 2);
        chk("rs_done_at", 32'(done_at), 22);
`endif
        chk("rs_done_cnt", 32'(done_cnt), 1);

        // start and hold together in IDLE: the load still happens.
        run_seq(30, 1'b1, 0, 0, 0, 0);
        chk("sh_phase_k1", 32'(ph_r[1]), 1);
        chk("sh_c_k1", 32'(c_r[1]), 7);
        chk("sh_c_k2", 32'(c_r[2]), 6);
        chk("sh_done_at", 32'(done_at), 22);

        // All-zero INIT instance: one cycle per phase, done at N+4.
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            ep = (k <= 4) ? k : 0;
            chk($sformatf("zero_phase_k%0d", k), 32'(bus0.phase), 32'(ep));
            chk($sformatf("zero_done_k%0d", k), 32'(bus0.done), 32'(k == 4));
            chk($sformatf("zero_busy_k%0d", k), 32'(bus0.busy), 32'(k <= 3));
            chk($sformatf("zero_abc_k%0d", k), 32'({bus0.a, bus0.b, bus0.c}), 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
